// File: rtl/sc_levels_pkg.sv
// Shared definitions for the Road Fighter level controller: FSM state
// encodings and default parameter values.
package sc_levels_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_IDLE     = 4'd1,
        ST_CLEAR    = 4'd2,
        ST_LOAD     = 4'd3,
        ST_PLAY     = 4'd4,
        ST_NEXT     = 4'd5,
        ST_DEAD     = 4'd6,
        ST_RESPAWN  = 4'd7,
        ST_GAMEOVER = 4'd8,
        ST_WIN      = 4'd9
    } state_e;

    localparam int unsigned DEF_NUM_LEVELS      = 4;
    localparam int unsigned DEF_LEVEL_W         = 3;
    localparam int unsigned DEF_OBJ_W           = 8;
    localparam int unsigned DEF_OBJ_TARGET_BASE = 20;
    localparam int unsigned DEF_OBJ_TARGET_STEP = 10;
    localparam int unsigned DEF_LIVES           = 3;
    localparam int unsigned DEF_LIVES_W         = 2;
    localparam int unsigned DEF_DEAD_HOLD       = 25_000_000;
    localparam int unsigned DEF_HOLD_W          = 25;

endpackage

// File: rtl/sc_counter_hold.sv
// Loadable down-counter with zero flag, used to time the DEAD hold.
// Ports: clk, rst (sync, active high), load/load_val (load has priority),
//        dec (decrement while non-zero), zero_c (count is zero).
module sc_counter_hold
    import sc_levels_pkg::*;
#(
    parameter int unsigned W = DEF_HOLD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count_q, count_d;

    // Next count: load wins, decrement saturates at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/sc_statemachine_level_ctrl.sv
// Game-level controller: start, per-level load, play, death/respawn with a
// lives budget, level advance on object target, game-over and win.
// Ports: 50 MHz clock, sync active-high reset, start button (low), collision
//        flag, fuel comparator (low), object count, loader done; outputs are
//        clear/load strobes (low), level, lives and four status flags.
module sc_statemachine_level_ctrl
    import sc_levels_pkg::*;
#(
    parameter int unsigned NUM_LEVELS      = DEF_NUM_LEVELS,
    parameter int unsigned LEVEL_W         = DEF_LEVEL_W,
    parameter int unsigned OBJ_W           = DEF_OBJ_W,
    parameter int unsigned OBJ_TARGET_BASE = DEF_OBJ_TARGET_BASE,
    parameter int unsigned OBJ_TARGET_STEP = DEF_OBJ_TARGET_STEP,
    parameter int unsigned LIVES           = DEF_LIVES,
    parameter int unsigned LIVES_W         = DEF_LIVES_W,
    parameter int unsigned DEAD_HOLD       = DEF_DEAD_HOLD,
    parameter int unsigned HOLD_W          = DEF_HOLD_W
) (
    input  logic               SC_STATEMACHINE_LEVELCTRL_CLOCK_50,
    input  logic               SC_STATEMACHINE_LEVELCTRL_RESET_InHigh,
    input  logic               SC_STATEMACHINE_LEVELCTRL_startButton_InLow,
    input  logic               SC_STATEMACHINE_LEVELCTRL_DeadFlag_InHigh,
    input  logic               SC_STATEMACHINE_LEVELCTRL_DeadComparator_InLow,
    input  logic [OBJ_W-1:0]   SC_STATEMACHINE_LEVELCTRL_ObjCount,
    input  logic               SC_STATEMACHINE_LEVELCTRL_loadDone_InHigh,
    output logic               SC_STATEMACHINE_LEVELCTRL_clear_OutLow,
    output logic               SC_STATEMACHINE_LEVELCTRL_load_OutLow,
    output logic [LEVEL_W-1:0] SC_STATEMACHINE_LEVELCTRL_Level,
    output logic [LIVES_W-1:0] SC_STATEMACHINE_LEVELCTRL_Lives,
    output logic               SC_STATEMACHINE_LEVELCTRL_Playing,
    output logic               SC_STATEMACHINE_LEVELCTRL_Dead,
    output logic               SC_STATEMACHINE_LEVELCTRL_GameOver,
    output logic               SC_STATEMACHINE_LEVELCTRL_Win
);

    localparam int unsigned TGT_W = OBJ_W + LEVEL_W;
    localparam logic [TGT_W-1:0] TGT_MAX = {{LEVEL_W{1'b0}}, {OBJ_W{1'b1}}};

    logic clk, rst, start_n, died, reached;
    assign clk     = SC_STATEMACHINE_LEVELCTRL_CLOCK_50;
    assign rst     = SC_STATEMACHINE_LEVELCTRL_RESET_InHigh;
    assign start_n = SC_STATEMACHINE_LEVELCTRL_startButton_InLow;

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               armed_q, armed_d;
    logic               clear_n_q, clear_n_d, load_n_q, load_n_d;
    logic               playing_q, playing_d, dead_q, dead_d;
    logic               gameover_q, gameover_d, win_q, win_d;
    logic               hold_load, hold_dec, hold_zero;
    logic [TGT_W-1:0]   target_raw, target_sat;

    // Object target for the current level, saturated to the count range
    always_comb begin
        target_raw = TGT_W'(OBJ_TARGET_BASE)
                   + TGT_W'(level_q - LEVEL_W'(1)) * TGT_W'(OBJ_TARGET_STEP);
        target_sat = (target_raw > TGT_MAX) ? TGT_MAX : target_raw;
    end

    assign died    = SC_STATEMACHINE_LEVELCTRL_DeadFlag_InHigh
                   | ~SC_STATEMACHINE_LEVELCTRL_DeadComparator_InLow;
    assign reached = (TGT_W'(SC_STATEMACHINE_LEVELCTRL_ObjCount) >= target_sat);

    sc_counter_hold #(.W(HOLD_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_W'(DEAD_HOLD - 1)),
        .dec      (hold_dec),
        .zero_c   (hold_zero)
    );

    // Next state, counters and registered output values
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        lives_d   = lives_q;
        armed_d   = 1'b0;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_IDLE;
            ST_IDLE: begin
                if (!start_n) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                level_d = LEVEL_W'(1);
                lives_d = LIVES_W'(LIVES);
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (SC_STATEMACHINE_LEVELCTRL_loadDone_InHigh) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Death outranks reaching the target in the same cycle
                if (died) begin
                    lives_d   = lives_q - LIVES_W'(1);
                    hold_load = 1'b1;
                    state_d   = ST_DEAD;
                end else if (reached) begin
                    state_d = (level_q == LEVEL_W'(NUM_LEVELS)) ? ST_WIN : ST_NEXT;
                end
            end
            ST_NEXT: begin
                level_d = level_q + LEVEL_W'(1);
                state_d = ST_LOAD;
            end
            ST_DEAD: begin
                if (hold_zero) begin
                    state_d = (lives_q == '0) ? ST_GAMEOVER : ST_RESPAWN;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            ST_RESPAWN: state_d = ST_LOAD;
            ST_GAMEOVER, ST_WIN: begin
                // Restart only on a press that follows a seen release
                armed_d = armed_q | start_n;
                if (armed_q && !start_n) begin
                    armed_d = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_RESET;
        endcase

        clear_n_d  = !(state_d inside {ST_CLEAR, ST_NEXT, ST_RESPAWN});
        load_n_d   = (state_d != ST_LOAD);
        playing_d  = (state_d == ST_PLAY);
        dead_d     = (state_d == ST_DEAD);
        gameover_d = (state_d == ST_GAMEOVER);
        win_d      = (state_d == ST_WIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            level_q    <= LEVEL_W'(1);
            lives_q    <= LIVES_W'(LIVES);
            armed_q    <= 1'b0;
            clear_n_q  <= 1'b1;
            load_n_q   <= 1'b1;
            playing_q  <= 1'b0;
            dead_q     <= 1'b0;
            gameover_q <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            lives_q    <= lives_d;
            armed_q    <= armed_d;
            clear_n_q  <= clear_n_d;
            load_n_q   <= load_n_d;
            playing_q  <= playing_d;
            dead_q     <= dead_d;
            gameover_q <= gameover_d;
            win_q      <= win_d;
        end
    end

    assign SC_STATEMACHINE_LEVELCTRL_clear_OutLow = clear_n_q;
    assign SC_STATEMACHINE_LEVELCTRL_load_OutLow  = load_n_q;
    assign SC_STATEMACHINE_LEVELCTRL_Level        = level_q;
    assign SC_STATEMACHINE_LEVELCTRL_Lives        = lives_q;
    assign SC_STATEMACHINE_LEVELCTRL_Playing      = playing_q;
    assign SC_STATEMACHINE_LEVELCTRL_Dead         = dead_q;
    assign SC_STATEMACHINE_LEVELCTRL_GameOver     = gameover_q;
    assign SC_STATEMACHINE_LEVELCTRL_Win          = win_q;

endmodule

// File: tb/tb_sc_statemachine_level_ctrl.sv
// Bench for sc_statemachine_level_ctrl: vector table, directed corner
// sequences and a randomized run against a behavioural game model.
module tb_sc_statemachine_level_ctrl;

    localparam int P_NUM   = 2;
    localparam int P_BASE  = 3;
    localparam int P_STEP  = 2;
    localparam int P_LIVES = 2;
    localparam int P_HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst, start_n, dflag, dcmp_n, ld;
    logic [7:0] obj;
    logic       clear_n, load_n, playing, dead, gameover, win;
    logic [2:0] level;
    logic [1:0] lives;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sc_statemachine_level_ctrl #(
        .NUM_LEVELS(P_NUM), .LEVEL_W(3), .OBJ_W(8),
        .OBJ_TARGET_BASE(P_BASE), .OBJ_TARGET_STEP(P_STEP),
        .LIVES(P_LIVES), .LIVES_W(2), .DEAD_HOLD(P_HOLD), .HOLD_W(4)
    ) dut (
        .SC_STATEMACHINE_LEVELCTRL_CLOCK_50            (clk),
        .SC_STATEMACHINE_LEVELCTRL_RESET_InHigh        (rst),
        .SC_STATEMACHINE_LEVELCTRL_startButton_InLow   (start_n),
        .SC_STATEMACHINE_LEVELCTRL_DeadFlag_InHigh     (dflag),
        .SC_STATEMACHINE_LEVELCTRL_DeadComparator_InLow(dcmp_n),
        .SC_STATEMACHINE_LEVELCTRL_ObjCount            (obj),
        .SC_STATEMACHINE_LEVELCTRL_loadDone_InHigh     (ld),
        .SC_STATEMACHINE_LEVELCTRL_clear_OutLow        (clear_n),
        .SC_STATEMACHINE_LEVELCTRL_load_OutLow         (load_n),
        .SC_STATEMACHINE_LEVELCTRL_Level               (level),
        .SC_STATEMACHINE_LEVELCTRL_Lives               (lives),
        .SC_STATEMACHINE_LEVELCTRL_Playing             (playing),
        .SC_STATEMACHINE_LEVELCTRL_Dead                (dead),
        .SC_STATEMACHINE_LEVELCTRL_GameOver            (gameover),
        .SC_STATEMACHINE_LEVELCTRL_Win                 (win)
    );

    // Output bundle {clear_n, load_n, level, lives, playing, dead, gameover, win}
    function automatic logic [11:0] pk(input bit c, input bit l, input int lvl,
                                       input int lv, input bit p, input bit d,
                                       input bit g, input bit w);
        return {c, l, 3'(lvl), 2'(lv), p, d, g, w};
    endfunction

    logic [11:0] got;
    assign got = {clear_n, load_n, level, lives, playing, dead, gameover, win};

    localparam logic [11:0] RST_OUT = {1'b1, 1'b1, 3'd1, 2'd2, 4'b0000};

    // Behavioural game model: phase of play plus level/lives/hold bookkeeping
    typedef enum int {M_BOOT, M_WAIT, M_CLR, M_LD, M_RUN, M_ADV, M_HIT,
                      M_RESP, M_OVER, M_WON} mode_t;
    mode_t m = M_BOOT;
    int    m_lvl = 1, m_lives = P_LIVES, m_hold = 0;
    bit    m_released = 1'b0;

    function automatic int tgt(input int lvl);
        int t;
        t = P_BASE + (lvl - 1) * P_STEP;
        return (t > 255) ? 255 : t;
    endfunction

    function automatic void model_step();
        if (rst) begin
            m = M_BOOT; m_lvl = 1; m_lives = P_LIVES; m_released = 1'b0;
            return;
        end
        case (m)
            M_BOOT: m = M_WAIT;
            M_WAIT: if (!start_n) m = M_CLR;
            M_CLR:  begin m_lvl = 1; m_lives = P_LIVES; m = M_LD; end
            M_LD:   if (ld) m = M_RUN;
            M_RUN: begin
                if (dflag || !dcmp_n) begin
                    m_lives = m_lives - 1; m_hold = P_HOLD; m = M_HIT;
                end else if (int'(obj) >= tgt(m_lvl)) begin
                    m_released = 1'b0;
                    m = (m_lvl == P_NUM) ? M_WON : M_ADV;
                end
            end
            M_ADV:  begin m_lvl = m_lvl + 1; m = M_LD; end
            M_HIT: begin
                m_hold = m_hold - 1;
                if (m_hold == 0) begin
                    m_released = 1'b0;
                    m = (m_lives == 0) ? M_OVER : M_RESP;
                end
            end
            M_RESP: m = M_LD;
            default: begin
                if (m_released && !start_n) begin
                    m = M_CLR; m_released = 1'b0;
                end else if (start_n) begin
                    m_released = 1'b1;
                end
            end
        endcase
    endfunction

    function automatic logic [11:0] model_out();
        return pk(!(m == M_CLR || m == M_ADV || m == M_RESP), m != M_LD,
                  m_lvl, m_lives, m == M_RUN, m == M_HIT, m == M_OVER, m == M_WON);
    endfunction

    task automatic drv(input bit r, input bit s, input bit df, input bit dc,
                       input int o, input bit l);
        rst = r; start_n = s; dflag = df; dcmp_n = dc; obj = 8'(o); ld = l;
    endtask

    // One clock: model sees the same inputs as the DUT, compare on falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        total++;
        if (got !== model_out()) begin
            bad++;
            $display("FAIL model_cycle t=%0t got=%h exp=%h", $time, got, model_out());
        end
    endtask

    task automatic chk(input string nm, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    typedef struct {
        bit          r, s, df, dc;
        int          o;
        bit          l;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1, 0, 0, 1, 0, 0, pk(1, 1, 1, 2, 0, 0, 0, 0)};
        vecs[1]  = '{0, 0, 0, 1, 0, 0, pk(1, 1, 1, 2, 0, 0, 0, 0)};
        vecs[2]  = '{0, 0, 0, 1, 0, 0, pk(0, 1, 1, 2, 0, 0, 0, 0)};
        vecs[3]  = '{0, 1, 0, 1, 0, 0, pk(1, 0, 1, 2, 0, 0, 0, 0)};
        vecs[4]  = '{0, 1, 0, 1, 0, 0, pk(1, 0, 1, 2, 0, 0, 0, 0)};
        vecs[5]  = '{0, 1, 0, 1, 0, 1, pk(1, 1, 1, 2, 1, 0, 0, 0)};
        vecs[6]  = '{0, 1, 0, 1, 2, 0, pk(1, 1, 1, 2, 1, 0, 0, 0)};
        vecs[7]  = '{0, 1, 0, 1, 3, 0, pk(0, 1, 1, 2, 0, 0, 0, 0)};
        vecs[8]  = '{0, 1, 0, 1, 0, 0, pk(1, 0, 2, 2, 0, 0, 0, 0)};
        vecs[9]  = '{0, 1, 0, 1, 0, 1, pk(1, 1, 2, 2, 1, 0, 0, 0)};
        vecs[10] = '{0, 1, 0, 1, 4, 0, pk(1, 1, 2, 2, 1, 0, 0, 0)};
        vecs[11] = '{0, 1, 0, 1, 5, 0, pk(1, 1, 2, 2, 0, 0, 0, 1)};
        vecs[12] = '{0, 0, 0, 1, 0, 0, pk(1, 1, 2, 2, 0, 0, 0, 1)};
        vecs[13] = '{0, 1, 0, 1, 0, 0, pk(1, 1, 2, 2, 0, 0, 0, 1)};
        vecs[14] = '{0, 0, 0, 1, 0, 0, pk(0, 1, 2, 2, 0, 0, 0, 0)};
        vecs[15] = '{0, 1, 0, 1, 0, 0, pk(1, 0, 1, 2, 0, 0, 0, 0)};

        drv(1, 1, 0, 1, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Start, load, level advance, win, restart
        for (int i = 0; i < 16; i++) begin
            drv(vecs[i].r, vecs[i].s, vecs[i].df, vecs[i].dc, vecs[i].o, vecs[i].l);
            tick();
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Death beats target, hold length, respawn at same level
        drv(0, 1, 0, 1, 0, 1); tick(); chk("play_l1", pk(1, 1, 1, 2, 1, 0, 0, 0));
        drv(0, 1, 1, 1, 3, 0); tick(); chk("death_beats_target", pk(1, 1, 1, 1, 0, 1, 0, 0));
        drv(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < P_HOLD - 1; i++) begin
            tick(); chk("dead_hold", pk(1, 1, 1, 1, 0, 1, 0, 0));
        end
        tick(); chk("respawn_clear", pk(0, 1, 1, 1, 0, 0, 0, 0));
        tick(); chk("reload_same_level", pk(1, 0, 1, 1, 0, 0, 0, 0));

        // Fuel death with last life, start held through game over
        drv(0, 1, 0, 1, 0, 1); tick(); chk("play_again", pk(1, 1, 1, 1, 1, 0, 0, 0));
        drv(0, 1, 0, 0, 0, 0); tick(); chk("fuel_death", pk(1, 1, 1, 0, 0, 1, 0, 0));
        drv(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < P_HOLD - 1; i++) begin
            tick(); chk("dead_hold2", pk(1, 1, 1, 0, 0, 1, 0, 0));
        end
        tick(); chk("gameover", pk(1, 1, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) begin
            tick(); chk("start_held_go", pk(1, 1, 1, 0, 0, 0, 1, 0));
        end
        drv(0, 1, 0, 1, 0, 0); tick(); chk("release_go", pk(1, 1, 1, 0, 0, 0, 1, 0));
        drv(0, 0, 0, 1, 0, 0); tick(); chk("restart_clear", pk(0, 1, 1, 0, 0, 0, 0, 0));
        drv(0, 1, 0, 1, 0, 0); tick(); chk("restart_load", pk(1, 0, 1, 2, 0, 0, 0, 0));

        // Reset mid-LOAD and mid-DEAD
        drv(1, 1, 0, 1, 0, 0); tick(); chk("rst_mid_load", RST_OUT);
        drv(0, 0, 0, 1, 0, 0); tick(); chk("idle_after_rst", RST_OUT);
        tick(); chk("held_start_clear", pk(0, 1, 1, 2, 0, 0, 0, 0));
        drv(0, 1, 0, 1, 0, 0); tick();
        drv(0, 1, 0, 1, 0, 1); tick();
        drv(0, 1, 1, 1, 0, 0); tick(); chk("dead_before_rst", pk(1, 1, 1, 1, 0, 1, 0, 0));
        drv(0, 1, 0, 1, 0, 0); tick();
        drv(1, 1, 0, 1, 0, 0); tick(); chk("rst_mid_dead", RST_OUT);

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            drv($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 29) != 0,
                int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sc_statemachine_level_ctrl.md
# sc_statemachine_level_ctrl

Parametrised game-level controller for the Road Fighter datapath. It sequences start, per-level board load, play, death/respawn with a lives budget, level advance on an object-count target, and game-over/win, for any number of levels. It sits between the debounced buttons and the background/object loaders. It drives their clear and load strobes and publishes level, lives and game status to the display and scoring blocks.

## Interface
- NUM_LEVELS, 4: number of levels; legal range 1..7.
- LEVEL_W, 3: width of the level output; must hold NUM_LEVELS.
- OBJ_W, 8: width of the object-count input.
- OBJ_TARGET_BASE, 20: object target for level 1.
- OBJ_TARGET_STEP, 10: target increment per level.
- LIVES, 3: lives at game start; legal range 1..(2^LIVES_W − 1).
- LIVES_W, 2: width of the lives counter.
- DEAD_HOLD, 25_000_000: cycles spent in DEAD before respawn; minimum 1.
- HOLD_W, 25: width of the dead-hold counter.

Ports:
- SC_STATEMACHINE_LEVELCTRL_CLOCK_50  in  1  system clock, 50 MHz.
- SC_STATEMACHINE_LEVELCTRL_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_STATEMACHINE_LEVELCTRL_startButton_InLow  in  1  debounced start button, active low.
- SC_STATEMACHINE_LEVELCTRL_DeadFlag_InHigh  in  1  collision detected.
- SC_STATEMACHINE_LEVELCTRL_DeadComparator_InLow  in  1  fuel exhausted, active low.
- SC_STATEMACHINE_LEVELCTRL_ObjCount  in  OBJ_W  objects passed in the current level.
- SC_STATEMACHINE_LEVELCTRL_loadDone_InHigh  in  1  loader finished.
- SC_STATEMACHINE_LEVELCTRL_clear_OutLow  out  1  clear strobe for counters and objects.
- SC_STATEMACHINE_LEVELCTRL_load_OutLow  out  1  load-level request.
- SC_STATEMACHINE_LEVELCTRL_Level  out  LEVEL_W  current level, 1-based.
- SC_STATEMACHINE_LEVELCTRL_Lives  out  LIVES_W  remaining lives.
- SC_STATEMACHINE_LEVELCTRL_Playing  out  1  high in PLAY only.
- SC_STATEMACHINE_LEVELCTRL_Dead  out  1  high in DEAD only.
- SC_STATEMACHINE_LEVELCTRL_GameOver  out  1  high in GAMEOVER only.
- SC_STATEMACHINE_LEVELCTRL_Win  out  1  high in WIN only.

## Operation
States and transitions:
- RESET: go to IDLE.
- IDLE: start pressed (input = 0) → CLEAR.
- CLEAR: clear_OutLow = 0 for one cycle; Level ← 1, Lives ← LIVES; → LOAD.
- LOAD: load_OutLow = 0 until loadDone_InHigh = 1 is sampled; then → PLAY.
- PLAY: evaluated in priority order:
  1. DeadFlag_InHigh = 1 or DeadComparator_InLow = 0: Lives ← Lives − 1, hold counter ← DEAD_HOLD − 1, → DEAD.
  2. ObjCount ≥ target(Level) and Level = NUM_LEVELS: → WIN.
  3. ObjCount ≥ target(Level) otherwise: → NEXT.
- NEXT: Level ← Level + 1; clear_OutLow = 0 for one cycle; → LOAD.
- DEAD: counter decrements each cycle. At 0: if Lives = 0 → GAMEOVER, else clear_OutLow = 0 for one cycle (as RESPAWN) → LOAD at the same level.
- GAMEOVER, WIN: hold until start is released and then pressed again (release-then-press edge) → CLEAR.

Arithmetic and boundaries:
- target(L) = OBJ_TARGET_BASE + (L − 1)·OBJ_TARGET_STEP, computed OBJ_W+LEVEL_W bits wide. If the result exceeds 2^OBJ_W − 1 it saturates to 2^OBJ_W − 1.
- Comparison is unsigned.
- Death and target reached in the same cycle: death wins.
- Start button is ignored in every state except IDLE, GAMEOVER and WIN.
- Start held through reset: IDLE exits immediately. Start held through GAMEOVER or WIN does not restart; a release is required first.
- Lives never underflow. Death occurs only in PLAY, and Lives ≥ 1 there.
- Any undefined state encoding → RESET.

## Timing
- All outputs are decoded from registered state and counters only. No input-to-output combinational path.
- Reset (synchronous) takes effect at the first clock edge with RESET_InHigh = 1. It overrides everything, including mid-LOAD and mid-DEAD.
- Reset output values: clear_OutLow = 1, load_OutLow = 1, Level = 1, Lives = LIVES, Playing = 0, Dead = 0, GameOver = 0, Win = 0.
- Start sampled low in IDLE at edge n: CLEAR during cycle n+1, LOAD from n+2.
- loadDone sampled at edge m: PLAY from cycle m+1, and load_OutLow returns high in the same cycle.
- Latency from PLAY to LOAD via death: exactly DEAD_HOLD + 1 cycles in DEAD/RESPAWN.
- Latency from target reached to LOAD via NEXT: 2 cycles.

## Structure
- Shared package sc_levels_pkg holds:
  - state encodings: RESET, IDLE, CLEAR, LOAD, PLAY, NEXT, DEAD, RESPAWN, GAMEOVER, WIN; 4-bit;
  - default parameter constants.
- One sub-module, sc_counter_hold: loadable down-counter of HOLD_W bits with a zero flag, used for the DEAD hold.
- Start-release tracking is a single register in this block.

## Test plan
Benches use NUM_LEVELS = 2, OBJ_TARGET_BASE = 3, OBJ_TARGET_STEP = 2, LIVES = 2, DEAD_HOLD = 4.
1. Reset, then start low for one cycle → clear_OutLow low for exactly 1 cycle; load_OutLow low until loadDone; then Playing = 1, Level = 1, Lives = 2.
2. In PLAY, ObjCount = 3 → NEXT then LOAD, Level = 2; ObjCount = 5 at level 2 → Win = 1.
3. DeadFlag pulse in PLAY → Dead = 1 for 4 cycles, Lives = 1, clear pulse, reload at the same level. A second death → GameOver = 1, Lives = 0.
4. DeadFlag = 1 and ObjCount = 3 in the same cycle → DEAD, Level stays 1.
5. Start held low from GAMEOVER entry → stays in GAMEOVER. Release, then press → CLEAR, Lives = 2, Level = 1.
6. RESET_InHigh asserted mid-LOAD and mid-DEAD → next cycle all outputs at reset values. DeadComparator_InLow = 0 → same behaviour as DeadFlag.
